get_bit: RTL and testbench

//  Decoder-side bitstream reader: unpacks the MSB-first byte stream that set_bit produces

---
 rtl/get_bit_pkg.sv | 8 +
 rtl/get_bit_extract.sv | 26 ++
 rtl/get_bit.sv | 149 ++++++++++++++
 tb/tb_get_bit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/get_bit_pkg.sv
// Shared types and defaults for the get_bit bitstream reader.
package get_bit_pkg;
  localparam int unsigned BUF_W_DEF   = 128;
  localparam int unsigned MAX_GET_DEF = 32;

  typedef enum logic [1:0] {GB_RUN, GB_DRAIN, GB_DONE} gb_state_t;
  typedef logic [5:0] gb_len_t;
endpackage

// File: rtl/get_bit_extract.sv
// Combinational field extractor: top len_i bits of the left-justified buffer,
// with bits past the valid level forced to zero, right-aligned in 32 bits.
module get_bit_extract
  import get_bit_pkg::*;
#(
  parameter int unsigned BUF_W = BUF_W_DEF
) (
  input  logic [BUF_W-1:0] bits_i,
  input  logic [7:0]       level_i,
  input  gb_len_t          len_i,
  output logic [31:0]      data_o
);
  logic [31:0] top;
  logic [31:0] vmask;
  logic [31:0] padded;

  always_comb begin
    top    = bits_i[BUF_W-1 -: 32];
    vmask  = (level_i >= 8'd32) ? '1 : ~(32'hFFFF_FFFF >> level_i);
    padded = top & vmask;
    data_o = '0;
    if (len_i != '0 && len_i <= 6'd32) begin
      data_o = padded >> (6'd32 - len_i);
    end
  end
endmodule

// File: rtl/get_bit.sv
// MSB-first bitstream reader: byte words in, 1..32-bit fields out, byte align on demand.
// Optional `GET_BIT_PEEK_EN adds req_peek (return field without consuming).
module get_bit
  import get_bit_pkg::*;
#(
  parameter int unsigned BUF_W   = BUF_W_DEF,
  parameter int unsigned MAX_GET = MAX_GET_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic [3:0]  in_byte_count,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        req_valid,
  input  logic [5:0]  req_bits,
  input  logic        req_align,
`ifdef GET_BIT_PEEK_EN
  input  logic        req_peek,
`endif
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_underrun,
  output logic        rsp_error,
  output logic [31:0] consumed_bytes,
  output logic        done
);
  localparam logic [8:0] CAP  = 9'(BUF_W);
  localparam gb_len_t    MAXG = gb_len_t'(MAX_GET);

  gb_state_t        state_q, state_d;
  logic [BUF_W-1:0] bits_q, bits_d;
  logic [7:0]       level_q, level_d;
  logic [31:0]      bit_pos_q, bit_pos_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_underrun_q, rsp_underrun_d;
  logic             rsp_error_q, rsp_error_d;

  logic             peek;
  logic             cnt_ok, in_fire, req_fire, bits_ill;
  logic [8:0]       in_fill;
  logic [7:0]       take, base, align_n;
  logic [63:0]      in_mask;
  logic [BUF_W-1:0] app;
  logic [31:0]      field;

`ifdef GET_BIT_PEEK_EN
  assign peek = req_peek;
`else
  assign peek = 1'b0;
`endif

  assign cnt_ok   = (in_byte_count != 4'd0) && (in_byte_count <= 4'd8);
  assign in_fill  = {1'b0, level_q} + {2'b0, in_byte_count, 3'b0};
  assign in_ready = (state_q == GB_RUN) && cnt_ok && (in_fill <= CAP);
  assign in_fire  = in_valid && in_ready;

  assign bits_ill  = (req_bits == '0) || (req_bits > MAXG);
  assign req_ready = (state_q == GB_DONE) || (state_q == GB_DRAIN) ||
                     (state_q == GB_RUN && (req_align || bits_ill ||
                                            level_q >= {2'b0, req_bits}));
  assign req_fire  = req_valid && req_ready;

  // Level is always congruent to -bit_pos mod 8, so an align never exceeds level.
  assign align_n = {5'b0, 3'd0 - bit_pos_q[2:0]};
  assign in_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {in_byte_count, 3'b0});

  get_bit_extract #(.BUF_W(BUF_W)) u_extract (
    .bits_i  (bits_q),
    .level_i (level_q),
    .len_i   (req_bits),
    .data_o  (field)
  );

  always_comb begin
    take           = '0;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = '0;
    rsp_underrun_d = 1'b0;
    rsp_error_d    = 1'b0;
    if (req_fire) begin
      rsp_valid_d = 1'b1;
      if (state_q == GB_DONE) begin
        rsp_underrun_d = 1'b1;
        rsp_error_d    = !req_align && bits_ill;
      end else if (req_align) begin
        take = align_n;
      end else if (bits_ill) begin
        rsp_error_d = 1'b1;
      end else begin
        rsp_data_d = field;
        if (level_q >= {2'b0, req_bits}) begin
          take = {2'b0, req_bits};
        end else begin
          take           = level_q;
          rsp_underrun_d = 1'b1;
        end
      end
      if (peek) take = '0;
    end

    // Incoming bytes land directly below whatever survives this cycle's consume.
    base      = level_q - take;
    app       = in_fire ? ({in_data & in_mask, {(BUF_W-64){1'b0}}} >> base) : '0;
    bits_d    = (bits_q << take) | app;
    level_d   = base + (in_fire ? {1'b0, in_byte_count, 3'b0} : 8'd0);
    bit_pos_d = bit_pos_q + 32'(take);

    state_d = state_q;
    unique case (state_q)
      GB_RUN:   if (in_fire && in_last) state_d = GB_DRAIN;
      GB_DRAIN: if (level_d == '0) state_d = GB_DONE;
      default:  state_d = state_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state_q        <= GB_RUN;
      bits_q         <= '0;
      level_q        <= '0;
      bit_pos_q      <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_underrun_q <= 1'b0;
      rsp_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      bits_q         <= bits_d;
      level_q        <= level_d;
      bit_pos_q      <= bit_pos_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_underrun_q <= rsp_underrun_d;
      rsp_error_q    <= rsp_error_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_underrun   = rsp_underrun_q;
  assign rsp_error      = rsp_error_q;
  assign consumed_bytes = {3'b0, bit_pos_q[31:3]};
  assign done           = (state_q == GB_DONE);
endmodule

// File: tb/tb_get_bit.sv
// Directed bench for get_bit; define GET_BIT_PEEK_EN to also cover req_peek.
module tb_get_bit;
  logic        clock = 1'b0;
  logic        reset, clear;
  logic        in_valid, in_last, in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_byte_count;
  logic        req_valid, req_align, req_ready;
  logic [5:0]  req_bits;
  logic        req_peek;
  logic        rsp_valid, rsp_underrun, rsp_error, done;
  logic [31:0] rsp_data, consumed_bytes;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clock = ~clock;

  get_bit dut (
    .clock          (clock),
    .reset          (reset),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_byte_count  (in_byte_count),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .req_valid      (req_valid),
    .req_bits       (req_bits),
    .req_align      (req_align),
`ifdef GET_BIT_PEEK_EN
    .req_peek       (req_peek),
`endif
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_underrun   (rsp_underrun),
    .rsp_error      (rsp_error),
    .consumed_bytes (consumed_bytes),
    .done           (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [3:0] c, input logic l);
    in_valid = 1'b1; in_data = d; in_byte_count = c; in_last = l;
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_byte_count = 4'd1;
  endtask

  task automatic get(input logic [5:0] b, input logic al, input logic pk);
    req_valid = 1'b1; req_bits = b; req_align = al; req_peek = pk;
    tick();
    req_valid = 1'b0; req_align = 1'b0; req_peek = 1'b0; req_bits = 6'd1;
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] d, input logic u, input logic e);
    chk({tag, ".valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, ".data"}, rsp_data, d);
    chk({tag, ".underrun"}, {31'b0, rsp_underrun}, {31'b0, u});
    chk({tag, ".error"}, {31'b0, rsp_error}, {31'b0, e});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0;
    in_valid = 1'b0; in_data = '0; in_byte_count = 4'd1; in_last = 1'b0;
    req_valid = 1'b0; req_bits = 6'd1; req_align = 1'b0; req_peek = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst.req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst.consumed", consumed_bytes, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);

    // 1: basic fields
    push(64'hA500_0000_0000_0000, 4'd1, 1'b0);
    get(6'd3, 1'b0, 1'b0); expect_rsp("t1.get3", 32'h5, 1'b0, 1'b0);
    get(6'd5, 1'b0, 1'b0); expect_rsp("t1.get5", 32'h05, 1'b0, 1'b0);
    chk("t1.consumed", consumed_bytes, 32'd1);
    tick();
    chk("t1.pulse", {31'b0, rsp_valid}, 32'd0);

    // 2: request waits for data
    push(64'h3C00_0000_0000_0000, 4'd1, 1'b0);
    req_bits = 6'd12; #1;
    chk("t2.req_ready", {31'b0, req_ready}, 32'd0);
    push(64'hFF00_0000_0000_0000, 4'd1, 1'b0);
    get(6'd12, 1'b0, 1'b0); expect_rsp("t2.get12", 32'h3CF, 1'b0, 1'b0);

    // 3: byte alignment
    get(6'd0, 1'b1, 1'b0); expect_rsp("t3.alignA", 32'h0, 1'b0, 1'b0);
    chk("t3.consA", consumed_bytes, 32'd3);
    push(64'h8000_0000_0000_0000, 4'd1, 1'b0);
    get(6'd3, 1'b0, 1'b0); expect_rsp("t3.get3", 32'h4, 1'b0, 1'b0);
    chk("t3.cons3", consumed_bytes, 32'd3);
    get(6'd0, 1'b1, 1'b0); expect_rsp("t3.align5", 32'h0, 1'b0, 1'b0);
    chk("t3.cons4", consumed_bytes, 32'd4);
    get(6'd0, 1'b1, 1'b0); expect_rsp("t3.align0", 32'h0, 1'b0, 1'b0);
    chk("t3.cons4b", consumed_bytes, 32'd4);

    // 4: full buffer backpressure with a same-cycle consume
    push(64'h0123_4567_89AB_CDEF, 4'd8, 1'b0);
    push(64'h1122_3344_5566_77FF, 4'd7, 1'b0);
    in_valid = 1'b1; in_data = 64'hBEEF_0000_0000_0000; in_byte_count = 4'd2;
    req_valid = 1'b1; req_bits = 6'd16; #1;
    chk("t4.in_ready_full", {31'b0, in_ready}, 32'd0);
    chk("t4.req_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    expect_rsp("t4.get16", 32'h0123, 1'b0, 1'b0);
    chk("t4.in_ready_next", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_byte_count = 4'd1;
    get(6'd32, 1'b0, 1'b0); expect_rsp("t4.r1", 32'h4567_89AB, 1'b0, 1'b0);
    get(6'd32, 1'b0, 1'b0); expect_rsp("t4.r2", 32'hCDEF_1122, 1'b0, 1'b0);
    get(6'd32, 1'b0, 1'b0); expect_rsp("t4.r3", 32'h3344_5566, 1'b0, 1'b0);
    get(6'd24, 1'b0, 1'b0); expect_rsp("t4.r4", 32'h77_BEEF, 1'b0, 1'b0);
    chk("t4.consumed", consumed_bytes, 32'd21);

    // simultaneous append and consume
    push(64'h5A00_0000_0000_0000, 4'd1, 1'b0);
    in_valid = 1'b1; in_data = 64'h9600_0000_0000_0000; in_byte_count = 4'd1;
    req_valid = 1'b1; req_bits = 6'd4;
    tick();
    in_valid = 1'b0; req_valid = 1'b0;
    expect_rsp("sim.get4", 32'h5, 1'b0, 1'b0);
    get(6'd12, 1'b0, 1'b0); expect_rsp("sim.get12", 32'hA96, 1'b0, 1'b0);
    chk("sim.consumed", consumed_bytes, 32'd23);

    // 5: end of stream
    push(64'hC000_0000_0000_0000, 4'd1, 1'b1);
    chk("t5.in_ready", {31'b0, in_ready}, 32'd0);
    get(6'd4, 1'b0, 1'b0); expect_rsp("t5.get4", 32'hC, 1'b0, 1'b0);
    chk("t5.not_done", {31'b0, done}, 32'd0);
    get(6'd8, 1'b0, 1'b0); expect_rsp("t5.get8", 32'h00, 1'b1, 1'b0);
    chk("t5.done", {31'b0, done}, 32'd1);
    req_bits = 6'd5; #1;
    chk("t5.req_ready_done", {31'b0, req_ready}, 32'd1);
    get(6'd5, 1'b0, 1'b0); expect_rsp("t5.get_done", 32'h0, 1'b1, 1'b0);
    chk("t5.consumed", consumed_bytes, 32'd24);

    // 6: illegal widths, partial drain, clear mid-drain
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t6.clr_consumed", consumed_bytes, 32'd0);
    chk("t6.clr_done", {31'b0, done}, 32'd0);
    push(64'hA500_0000_0000_0000, 4'd1, 1'b0);
    req_bits = 6'd0; #1;
    chk("t6.req_ready0", {31'b0, req_ready}, 32'd1);
    get(6'd0, 1'b0, 1'b0); expect_rsp("t6.bits0", 32'h0, 1'b0, 1'b1);
    get(6'd33, 1'b0, 1'b0); expect_rsp("t6.bits33", 32'h0, 1'b0, 1'b1);
    chk("t6.cons_unchanged", consumed_bytes, 32'd0);
    get(6'd8, 1'b0, 1'b0); expect_rsp("t6.get8", 32'hA5, 1'b0, 1'b0);
    push(64'h9D00_0000_0000_0000, 4'd1, 1'b1);
    get(6'd4, 1'b0, 1'b0); expect_rsp("t6.d4", 32'h9, 1'b0, 1'b0);
    get(6'd8, 1'b0, 1'b0); expect_rsp("t6.d8", 32'hD0, 1'b1, 1'b0);
    chk("t6.done", {31'b0, done}, 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    push(64'hB700_0000_0000_0000, 4'd1, 1'b1);
    get(6'd4, 1'b0, 1'b0); expect_rsp("t6.b4", 32'hB, 1'b0, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;
    #1;
    chk("t6.mid_in_ready", {31'b0, in_ready}, 32'd1);
    chk("t6.mid_consumed", consumed_bytes, 32'd0);
    chk("t6.mid_req_ready", {31'b0, req_ready}, 32'd0);
    chk("t6.mid_done", {31'b0, done}, 32'd0);

`ifdef GET_BIT_PEEK_EN
    push(64'h6B00_0000_0000_0000, 4'd1, 1'b0);
    get(6'd8, 1'b0, 1'b1); expect_rsp("pk.peek1", 32'h6B, 1'b0, 1'b0);
    chk("pk.cons1", consumed_bytes, 32'd0);
    get(6'd8, 1'b0, 1'b1); expect_rsp("pk.peek2", 32'h6B, 1'b0, 1'b0);
    get(6'd8, 1'b0, 1'b0); expect_rsp("pk.get", 32'h6B, 1'b0, 1'b0);
    chk("pk.cons2", consumed_bytes, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
